// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: D = A - B - Bin, Bout = borrow.
module fs_cell (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin, LSB first, one bit per clock.
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | shifting one bit per cycle through the full-subtractor cell
// DONE  | result presented, waiting for the consumer
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             br;
    logic             br_next;
    logic             d;
    logic [CW-1:0]    cnt;

    fs_cell u_fs_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Bin  (br),
        .D    (d),
        .Bout (br_next)
    );

    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = d;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result registers are updated only on completion so diff/bout hold
    // the last result through IDLE and the next RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        cnt  <= '0;
                        res  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    res  <= res_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_r <= res_next;
                        bout_r <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and exhaustive checks of serial_sub with a queue-based scoreboard.
module tb_serial_sub;

    localparam int W   = 3;
    localparam int BUD = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic binv, input bit push);
        int n = 0;
        a        = av;
        b        = bv;
        bin      = binv;
        in_valid = 1'b1;
        while (!in_ready && n < BUD) begin
            step();
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        if (push) exp_q.push_back({1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv});
        step();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
    endtask

    task automatic collect(input int lat0, input int stall);
        int         lat = lat0;
        logic [W-1:0] d0;
        logic         b0;
        logic [W:0]   e;
        while (!out_valid && lat < BUD) begin
            check("in_ready_run", 32'(in_ready), 32'd0);
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(W));
        d0 = diff;
        b0 = bout;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_stable", 32'({bout, diff}), 32'({b0, d0}));
        end
        out_ready = 1'b1;
        check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("result", 32'({bout, diff}), 32'(e));
        step();
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic binv, input int stall);
        out_ready = (stall == 0);
        accept(av, bv, binv, 1'b1);
        collect(0, stall);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'({bout, diff}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        run(3'd5, 3'd3, 1'b0, 0);
        run(3'd3, 3'd5, 1'b0, 0);
        run(3'd0, 3'd0, 1'b1, 0);
        run(3'd7, 3'd7, 1'b1, 0);

        run(3'd6, 3'd1, 1'b1, 5);
        for (int i = 0; i < 2; i++) begin
            step();
            check("single_handshake", 32'(out_valid), 32'd0);
        end

        // A second operand offered during RUN must be ignored.
        out_ready = 1'b1;
        accept(3'd7, 3'd0, 1'b0, 1'b1);
        a        = 3'd1;
        b        = 3'd2;
        bin      = 1'b0;
        in_valid = 1'b1;
        check("busy_run", 32'(busy), 32'd1);
        step();
        in_valid = 1'b0;
        collect(1, 0);

        // Reset during the second RUN cycle discards the transaction.
        accept(3'd5, 3'd1, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'({bout, diff}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run(v[2:0], v[5:3], v[6], int'($urandom_range(0, 3)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
